// File: rtl/verify_pkg.sv
// Shared definitions for the verify-code sequencer: FSM encoding, CRC-8 constants
// and the single-bit CRC step used by both the datapath and its reference model.
package verify_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] CRC8_POLY = 8'h25;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    function automatic logic [7:0] crc8_step_poly(input logic [7:0] crc,
                                                  input logic       din,
                                                  input logic [7:0] poly);
        logic fb;
        fb = din ^ crc[7];
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        return crc8_step_poly(crc, din, CRC8_POLY);
    endfunction

endpackage

// File: rtl/verify_crc8_core.sv
// Bit-serial CRC-8 register: preset on load, one message bit per shift_en cycle.
module verify_crc8_core
    import verify_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       DOUB_BLF,
    input  logic       rst,
    input  logic       load,
    input  logic       shift_en,
    input  logic       data_bit,
    output logic [7:0] crc
);

    // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge DOUB_BLF or posedge rst) begin
        if (rst) begin
            crc <= INIT;
        end else if (load) begin
            crc <= INIT;
        end else if (shift_en) begin
            crc <= crc8_step_poly(crc, data_bit, POLY);
        end
    end

endmodule

// File: rtl/verify_sched.sv
// Round-robin arbiter plus serial CRC-8 sequencer for command-layer verify codes.
// Optional `define VER_CHECK_EN adds exp_code / ver_ok for an in-line code compare.
module verify_sched
    import verify_pkg::*;
#(
    parameter int         NREQ  = 3,
    parameter int         WIDTH = 16,
    parameter logic [7:0] POLY  = CRC8_POLY,
    parameter logic [7:0] INIT  = CRC8_INIT
) (
    input  logic                  DOUB_BLF,
    input  logic                  rst,
    input  logic                  new_cmd,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [2:0]            gnt_id,
    output logic                  busy,
    output logic [7:0]            ver_code,
    output logic                  ver_done
`ifdef VER_CHECK_EN
    ,
    input  logic [7:0]            exp_code,
    output logic                  ver_ok
`endif
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [2:0]       ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_sel;
    logic [7:0]       crc;
    logic [7:0]       crc_final;
    logic             win_found;
    logic [2:0]       win_id;
    logic             last_bit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && req[j] && (j == (int'(ptr) + i) % NREQ)) begin
                    win_found = 1'b1;
                    win_id    = 3'(j);
                end
            end
        end
    end

    always_comb begin
        word_sel = '0;
        grant    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt_id == 3'(j)) begin
                word_sel = req_data[j*WIDTH +: WIDTH];
                grant[j] = (state == LOAD) && !new_cmd;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign ver_done  = (state == DONE);
    assign last_bit  = (state == SHIFT) && (cnt == '0);
    // Code as it will stand after the final shift, so ver_code is valid during DONE.
    assign crc_final = crc8_step_poly(crc, shreg[WIDTH-1], POLY);

    verify_crc8_core #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_crc (
        .DOUB_BLF (DOUB_BLF),
        .rst      (rst),
        .load     ((state == LOAD) && !new_cmd),
        .shift_en ((state == SHIFT) && !new_cmd),
        .data_bit (shreg[WIDTH-1]),
        .crc      (crc)
    );

    always_ff @(posedge DOUB_BLF or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_id   <= '0;
            ptr      <= '0;
            cnt      <= '0;
            shreg    <= '0;
            ver_code <= INIT;
        end else if (new_cmd) begin
            state    <= IDLE;
            ver_code <= INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state  <= LOAD;
                        gnt_id <= win_id;
                    end
                end
                LOAD: begin
                    shreg <= word_sel;
                    cnt   <= CW'(WIDTH - 1);
                    ptr   <= (gnt_id == 3'(NREQ - 1)) ? 3'd0 : gnt_id + 3'd1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        state    <= DONE;
                        ver_code <= crc_final;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VER_CHECK_EN
    logic [7:0] exp_q;

    always_ff @(posedge DOUB_BLF or posedge rst) begin
        if (rst) begin
            exp_q  <= '0;
            ver_ok <= 1'b0;
        end else if (new_cmd) begin
            ver_ok <= 1'b0;
        end else if (state == LOAD) begin
            exp_q <= exp_code;
        end else if (last_bit) begin
            ver_ok <= (crc_final == exp_q);
        end
    end
`endif

endmodule

// File: tb/tb_verify_sched.sv
// Randomized scoreboard bench for verify_sched against a round-robin / CRC-8 reference model.
module tb_verify_sched;
    import verify_pkg::*;

    localparam int NREQ  = 3;
    localparam int WIDTH = 16;
    localparam int LAT   = WIDTH + 1;

    logic                  DOUB_BLF = 1'b0;
    logic                  rst;
    logic                  new_cmd;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic [2:0]            gnt_id;
    logic                  busy;
    logic [7:0]            ver_code;
    logic                  ver_done;
`ifdef VER_CHECK_EN
    logic [7:0]            exp_code;
    logic                  ver_ok;
`endif

    logic [WIDTH-1:0] words [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_data[g*WIDTH +: WIDTH] = words[g];
    end

    verify_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .DOUB_BLF (DOUB_BLF),
        .rst      (rst),
        .new_cmd  (new_cmd),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .ver_code (ver_code),
        .ver_done (ver_done)
`ifdef VER_CHECK_EN
        ,
        .exp_code (exp_code),
        .ver_ok   (ver_ok)
`endif
    );

    always #5 DOUB_BLF = ~DOUB_BLF;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    always @(posedge DOUB_BLF) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] code;
        logic       ok;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    bit         mon_en    = 1'b0;
    bit         pending   = 1'b0;
    logic [7:0] pend_code = '0;
    logic       pend_ok   = 1'b0;
    int         grant_cyc = 0;
    int         m_ptr     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference CRC: the whole word, MSB first, from the preset.
    function automatic logic [7:0] model_crc(input logic [WIDTH-1:0] w);
        logic [7:0] c;
        c = CRC8_INIT;
        for (int b = WIDTH - 1; b >= 0; b--) c = crc8_step(c, w[b]);
        return c;
    endfunction

    // Round-robin: first pending requester at or after the pointer, cyclically.
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic expect_grant(input int w);
        exp_t e;
        e.id   = w;
        e.code = model_crc(words[w]);
`ifdef VER_CHECK_EN
        e.ok   = (e.code == exp_code);
`else
        e.ok   = 1'b0;
`endif
        sb_q.push_back(e);
        m_ptr = (w + 1) % NREQ;
    endtask

    always @(negedge DOUB_BLF) begin
        if (mon_en && !rst) begin
            if (grant != '0) begin
                check("grant_onehot", 32'($onehot(grant)), 32'd1);
                if (sb_q.size() == 0) begin
                    check("grant_unexpected", 32'(grant), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("grant_id", 32'(gnt_id), mon_e.id);
                    check("grant_vec", 32'(grant), 32'd1 << mon_e.id);
                    pend_code = mon_e.code;
                    pend_ok   = mon_e.ok;
                    pending   = 1'b1;
                    grant_cyc = cyc;
                end
            end
            if (ver_done) begin
                check("done_expected", 32'(pending), 32'd1);
                check("done_latency", cyc - grant_cyc, LAT);
                check("ver_code", 32'(ver_code), 32'(pend_code));
`ifdef VER_CHECK_EN
                check("ver_ok", 32'(ver_ok), 32'(pend_ok));
`endif
                pending = 1'b0;
            end
        end
    end

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((pending || sb_q.size() != 0) && guard < 200) begin
            @(negedge DOUB_BLF);
            guard++;
        end
        check("drain_timeout", 32'(guard < 200), 32'd1);
        @(negedge DOUB_BLF);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        do begin
            @(negedge DOUB_BLF);
            guard++;
        end while (!ver_done && guard < 100);
        check("done_timeout", 32'(ver_done), 32'd1);
    endtask

    // Requesters hold req until granted; the granted word is scrambled once past LOAD.
    task automatic serve(input logic [NREQ-1:0] mask, input bit rnd);
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] scr;
        int              guard;
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) if (mask[i]) words[i] = WIDTH'($urandom);
        end
        r = mask;
        while (r != '0) begin
            int w;
            w = pick(r);
            expect_grant(w);
            r[w] = 1'b0;
        end
        req   = mask;
        scr   = '0;
        guard = 0;
        while (req != '0 && guard < 400) begin
            @(negedge DOUB_BLF);
            guard++;
            for (int i = 0; i < NREQ; i++) if (scr[i]) words[i] = WIDTH'($urandom);
            scr = grant;
            req = req & ~grant;
        end
        check("serve_timeout", 32'(guard < 400), 32'd1);
        @(negedge DOUB_BLF);
        for (int i = 0; i < NREQ; i++) if (scr[i]) words[i] = WIDTH'($urandom);
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst     = 1'b0;
        new_cmd = 1'b0;
        req     = '0;
        for (int i = 0; i < NREQ; i++) words[i] = '0;
`ifdef VER_CHECK_EN
        exp_code = 8'h00;
`endif
        #3 rst = 1'b1;
        @(negedge DOUB_BLF);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_gnt_id", 32'(gnt_id), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(ver_done), 32'd0);
        check("reset_code", 32'(ver_code), 32'hFF);
`ifdef VER_CHECK_EN
        check("reset_ver_ok", 32'(ver_ok), 32'd0);
`endif
        @(negedge DOUB_BLF);
        rst = 1'b0;
        @(negedge DOUB_BLF);
        mon_en = 1'b1;

        // Round-robin with all three held: 0,1,2 then wrap to 0.
        for (int i = 0; i < NREQ; i++) words[i] = WIDTH'($urandom);
        for (int k = 0; k < 4; k++) expect_grant(pick('1));
        req = '1;
        n   = 0;
        for (int g = 0; g < 300 && n < 4; g++) begin
            @(negedge DOUB_BLF);
            if (grant != '0) n++;
        end
        req = '0;
        check("rr_grant_count", n, 4);
        wait_drain();

        // Single request, zero word.
        words[0] = '0;
        expect_grant(0);
        req = 3'b001;
        @(negedge DOUB_BLF);
        check("single_grant", 32'(grant), 32'b001);
        req = '0;
        wait_done();
        check("single_code", 32'(ver_code), 32'h5C);
        wait_drain();

        // Abort in the 6th SHIFT cycle; the held request is served again from scratch.
        words[1] = WIDTH'($urandom);
        expect_grant(1);
        expect_grant(1);
        req = 3'b010;
        @(negedge DOUB_BLF);
        check("abort_first_grant", 32'(grant), 32'b010);
        repeat (6) @(negedge DOUB_BLF);
        check("abort_busy_before", 32'(busy), 32'd1);
        new_cmd = 1'b1;
        @(negedge DOUB_BLF);
        new_cmd = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(ver_done), 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_code", 32'(ver_code), 32'hFF);
        @(negedge DOUB_BLF);
        check("abort_regrant", 32'(grant), 32'b010);
        req = '0;
        wait_drain();

        // new_cmd together with a request in IDLE.
        words[2] = WIDTH'($urandom);
        expect_grant(2);
        req     = 3'b100;
        new_cmd = 1'b1;
        @(negedge DOUB_BLF);
        check("sim_grant_blocked", 32'(grant), 32'd0);
        check("sim_busy", 32'(busy), 32'd0);
        new_cmd = 1'b0;
        @(negedge DOUB_BLF);
        check("sim_grant_after", 32'(grant), 32'b100);
        req = '0;
        wait_drain();

        // Reset mid-SHIFT after granting requester 1 (pointer would otherwise be 2).
        mon_en = 1'b0;
        req    = 3'b010;
        @(negedge DOUB_BLF);
        check("rst_pre_grant", 32'(grant), 32'b010);
        req = '0;
        repeat (4) @(negedge DOUB_BLF);
        #2 rst = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(ver_done), 32'd0);
        check("rst_code", 32'(ver_code), 32'hFF);
        @(negedge DOUB_BLF);
        rst = 1'b0;
        sb_q.delete();
        pending = 1'b0;
        m_ptr   = 0;
        mon_en  = 1'b1;
        @(negedge DOUB_BLF);
        serve('1, 1'b1);

        repeat (25) serve(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b1);

`ifdef VER_CHECK_EN
        words[0] = '0;
        exp_code = 8'h5C;
        serve(3'b001, 1'b0);
        check("vok_hold_1", 32'(ver_ok), 32'd1);
        words[0] = '0;
        exp_code = 8'h00;
        serve(3'b001, 1'b0);
        check("vok_hold_0", 32'(ver_ok), 32'd0);
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
